// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data access.
// Data access wins by default; a streak limit keeps fetch from starving.
module mem_arbiter #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int ACK_TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(MAX_DM_STREAK);
  localparam logic [TW-1:0] TLAST =
    TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] AMASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            r_state, w_state;
  logic              r_own_dm, w_own_dm;
  logic [SW-1:0]     r_streak, w_streak;
  logic [TW-1:0]     r_tcnt, w_tcnt;
  logic              r_mreq, w_mreq;
  logic              r_mwe, w_mwe;
  logic [ADDR_W-1:0] r_maddr, w_maddr;
  logic [DATA_W-1:0] r_mwdata, w_mwdata;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata;
  logic              r_if_rdy, w_if_rdy;
  logic              r_dm_rdy, w_dm_rdy;
  logic              r_err, w_err;
  logic              w_grant_dm;
  logic              w_expired;

  always_comb begin
    w_state    = r_state;
    w_own_dm   = r_own_dm;
    w_streak   = r_streak;
    w_tcnt     = r_tcnt;
    w_mreq     = r_mreq;
    w_mwe      = r_mwe;
    w_maddr    = r_maddr;
    w_mwdata   = r_mwdata;
    w_if_rdata = r_if_rdata;
    w_dm_rdata = r_dm_rdata;
    w_if_rdy   = 1'b0;
    w_dm_rdy   = 1'b0;
    w_err      = 1'b0;
    w_grant_dm = dm_req && !(if_req && r_streak == SMAX);
    w_expired  = (ACK_TIMEOUT > 0) && (r_tcnt == TLAST);
    unique case (r_state)
      IDLE: begin
        if (!if_req) w_streak = '0;
        if (w_grant_dm) begin
          w_state  = ISSUE;
          w_own_dm = 1'b1;
          w_mreq   = 1'b1;
          w_mwe    = dm_we;
          w_maddr  = dm_addr & AMASK;
          w_mwdata = dm_wdata;
          w_tcnt   = '0;
          if (if_req && r_streak != SMAX)
            w_streak = r_streak + 1'b1;
        end else if (if_req) begin
          w_state  = ISSUE;
          w_own_dm = 1'b0;
          w_mreq   = 1'b1;
          w_mwe    = 1'b0;
          w_maddr  = if_addr & AMASK;
          w_mwdata = '0;
          w_tcnt   = '0;
          w_streak = '0;
        end
      end
      ISSUE: begin
        // an ack in the expiry cycle still counts as success
        if (mem_ack || w_expired) begin
          w_state  = RESP;
          w_mreq   = 1'b0;
          w_if_rdy = !r_own_dm;
          w_dm_rdy = r_own_dm;
          w_err    = !mem_ack;
          if (mem_ack && !r_mwe) begin
            if (r_own_dm) w_dm_rdata = mem_rdata;
            else          w_if_rdata = mem_rdata;
          end
        end else if (ACK_TIMEOUT > 0) begin
          w_tcnt = r_tcnt + 1'b1;
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_own_dm   <= 1'b0;
      r_streak   <= '0;
      r_tcnt     <= '0;
      r_mreq     <= 1'b0;
      r_mwe      <= 1'b0;
      r_maddr    <= '0;
      r_mwdata   <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_rdy   <= 1'b0;
      r_dm_rdy   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_own_dm   <= w_own_dm;
      r_streak   <= w_streak;
      r_tcnt     <= w_tcnt;
      r_mreq     <= w_mreq;
      r_mwe      <= w_mwe;
      r_maddr    <= w_maddr;
      r_mwdata   <= w_mwdata;
      r_if_rdata <= w_if_rdata;
      r_dm_rdata <= w_dm_rdata;
      r_if_rdy   <= w_if_rdy;
      r_dm_rdy   <= w_dm_rdy;
      r_err      <= w_err;
    end
  end

  assign mem_req   = r_mreq;
  assign mem_we    = r_mwe;
  assign mem_addr  = r_maddr;
  assign mem_wdata = r_mwdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ready  = r_if_rdy;
  assign dm_ready  = r_dm_rdy;
  assign err       = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed traffic against mem_arbiter.
// Scoreboard queues per requester plus an arbitration-rule model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_arbiter #(
    .DATA_W(32), .ADDR_W(32),
    .MAX_DM_STREAK(MAXS), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .err(err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string msg);
    n_chk++;
    n_err++;
    $display("FAIL %s", msg);
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // environment memory and reference memory kept separately
  logic [31:0] env_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (env_mem.exists(w)) return env_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  // memory responder: ack after a chosen number of mem_req cycles
  int          mem_fixed = -1;
  bit          mem_noack = 1'b0;
  int          mcnt = 0;
  int          mlat = 0;
  logic [31:0] last_ra = '0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  int          wr_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && rst_n) begin
        if (mcnt == 0)
          mlat = (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(0, 4));
        if (!mem_noack && mcnt == mlat) begin
          mem_ack = 1'b1;
          mcnt = 0;
          if (mem_we) begin
            env_mem[int'(mem_addr >> 2)] = mem_wdata;
            last_wa = mem_addr;
            last_wd = mem_wdata;
            wr_cnt++;
          end else begin
            mem_rdata = env_rd(mem_addr);
            last_ra = mem_addr;
          end
        end else begin
          mcnt++;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  bit          gq[$];
  exp_t        mon_e;
  logic [31:0] last_dm = '0;

  int          run = 0;
  bit          idle = 1'b1;
  bit          low_seen = 1'b0;
  bit          prev_if = 1'b0;
  bit          prev_dm = 1'b0;
  bit          prev_mreq = 1'b0;
  logic [31:0] prev_maddr = '0;
  int          req_run = 0;
  int          last_req_run = 0;
  int          dm_rdy_cnt = 0;
  int          dm_cnt_at_if = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      gq.delete();
      run = 0;
      idle = 1'b1;
      low_seen = 1'b0;
      req_run = 0;
    end else begin
      if (if_ready || dm_ready) begin
        chk("ready_onehot", if_ready & dm_ready, 1'b0);
        if (gq.size() == 0) fail("grant_owner: ready with no grant");
        else chk("grant_owner", dm_ready, gq.pop_front());
        if (if_ready) begin
          dm_cnt_at_if = dm_rdy_cnt;
          if (if_q.size() == 0) fail("if_unexpected_ready");
          else begin
            mon_e = if_q.pop_front();
            chk("if_rdata", if_rdata, mon_e.data);
            chk("if_err", err, mon_e.err);
          end
        end
        if (dm_ready) begin
          dm_rdy_cnt++;
          if (dm_q.size() == 0) fail("dm_unexpected_ready");
          else begin
            mon_e = dm_q.pop_front();
            chk("dm_rdata", dm_rdata, mon_e.data);
            chk("dm_err", err, mon_e.err);
          end
        end
        idle = 1'b1;
      end else if (err) begin
        fail("err_without_ready");
      end
      if (mem_req && prev_mreq)
        chk("mem_addr_stable", mem_addr, prev_maddr);
      if (mem_req && !prev_mreq) begin
        if (low_seen) run = 0;
        if (prev_dm && !(prev_if && run == MAXS)) begin
          gq.push_back(1'b1);
          if (prev_if && run < MAXS) run++;
        end else if (prev_if) begin
          gq.push_back(1'b0);
          run = 0;
        end else begin
          fail("spurious_grant");
        end
        idle = 1'b0;
        low_seen = 1'b0;
      end
      if (idle && !if_req) low_seen = 1'b1;
      if (mem_req) req_run++;
      else if (prev_mreq) begin
        last_req_run = req_run;
        req_run = 0;
      end
    end
    prev_mreq  = mem_req;
    prev_maddr = mem_addr;
    prev_if    = if_req;
    prev_dm    = dm_req;
  end

  task automatic if_txn(input logic [31:0] a, output int lat);
    exp_t e;
    int   n;
    int   c0;
    e.data = ref_rd(a);
    e.err  = 1'b0;
    if_q.push_back(e);
    if_req = 1'b1;
    if_addr = a;
    c0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready && n < 200);
    if (!if_ready) fail("if_wait: no if_ready within 200 cycles");
    lat = cyc - c0;
    @(posedge clk);
    #1;
    if_req = 1'b0;
    if_addr = $urandom;
  endtask

  task automatic dm_txn(input logic        we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input bit          to,
                        output int         lat);
    exp_t e;
    int   n;
    int   c0;
    e.err = to;
    if (to) begin
      e.data = last_dm;
    end else if (we) begin
      ref_mem[int'(a >> 2)] = d;
      e.data = last_dm;
    end else begin
      e.data = ref_rd(a);
      last_dm = e.data;
    end
    dm_q.push_back(e);
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = a;
    dm_wdata = d;
    c0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dm_ready && n < 200);
    if (!dm_ready) fail("dm_wait: no dm_ready within 200 cycles");
    lat = cyc - c0;
    @(posedge clk);
    #1;
    dm_req = 1'b0;
    dm_we = $urandom_range(0, 1);
    dm_addr = $urandom;
    dm_wdata = $urandom;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_if;
    int lat_dm;
    int d0;
    int w0;
    int n;
    env_mem[32'h40 >> 2] = 32'h2402000A;
    ref_mem[32'h40 >> 2] = 32'h2402000A;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_ready", if_ready, 1'b0);
    chk("rst_dm_ready", dm_ready, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    mem_fixed = 0;
    if_txn(32'h40, lat_if);
    chk("t1_latency", lat_if, 2);
    chk("t1_mem_addr", last_ra, 32'h40);
    chk("t1_req_cycles", last_req_run, 1);

    mem_fixed = 2;
    fork
      if_txn(32'h48, lat_if);
      dm_txn(1'b0, 32'h100, 32'h0, 1'b0, lat_dm);
    join
    chk("t2_dm_latency", lat_dm, 4);
    chk("t2_if_latency", lat_if, 9);

    mem_fixed = -1;
    w0 = wr_cnt;
    dm_txn(1'b1, 32'h203, 32'hDEADBEEF, 1'b0, lat_dm);
    chk("t4_write_seen", wr_cnt - w0, 1);
    chk("t4_mem_addr", last_wa, 32'h200);
    chk("t4_mem_wdata", last_wd, 32'hDEADBEEF);
    dm_txn(1'b0, 32'h200, 32'h0, 1'b0, lat_dm);

    d0 = dm_rdy_cnt;
    fork
      if_txn(32'h4C, lat_if);
      for (int i = 0; i < 6; i++)
        dm_txn(1'b0, 32'h2000 + 32'(4 * i), 32'h0, 1'b0, lat_dm);
    join
    chk("t3_dm_before_if", dm_cnt_at_if - d0, MAXS);

    fork
      begin
        int g;
        for (int i = 0; i < 40; i++) begin
          if_txn(32'($urandom_range(0, 4095)), lat_if);
          g = $urandom_range(0, 3);
          repeat (g) begin
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        int g;
        for (int i = 0; i < 40; i++) begin
          dm_txn(1'($urandom_range(0, 1)),
                 32'h2000 + 32'($urandom_range(0, 63)),
                 $urandom, 1'b0, lat_dm);
          g = $urandom_range(0, 3);
          repeat (g) begin
            @(posedge clk);
            #1;
          end
        end
      end
    join

    mem_noack = 1'b1;
    dm_txn(1'b0, 32'h2008, 32'h0, 1'b1, lat_dm);
    mem_noack = 1'b0;
    chk("t5_req_cycles", last_req_run, TMO);
    chk("t5_latency", lat_dm, TMO + 1);
    dm_txn(1'b0, 32'h2008, 32'h0, 1'b0, lat_dm);

    mem_noack = 1'b1;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 32'h2010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("t6_issue_started", mem_req, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_dm_rdata", dm_rdata, 32'h0);
    chk("t6_dm_ready", dm_ready, 1'b0);
    chk("t6_err", err, 1'b0);
    dm_req = 1'b0;
    last_dm = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    mem_noack = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    mem_fixed = 0;
    dm_txn(1'b0, 32'h2010, 32'h0, 1'b0, lat_dm);
    chk("t6_after_latency", lat_dm, 2);

    repeat (3) @(posedge clk);
    chk("if_queue_drained", if_q.size(), 0);
    chk("dm_queue_drained", dm_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
